// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : 5-stage pipeline sequencer: stage valids, allow-in chain,
//            instruction-fetch FSM, load-use stall and jump/branch squash.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int CNT_W  = 16,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic              inst_req_o,
    input  logic              inst_addr_ok_i,
    input  logic              inst_data_ok_i,
    output logic              pc_en_o,
    output logic              ctl_if_over_o,
    output logic              ctl_id_allow_in_o,
    output logic              ctl_jbr_taken_o,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_is_load_i,
    input  logic              ex_over_i,
    input  logic              mem_over_i,
    input  logic              jbr_taken_i,
    output logic              id_valid_o,
    output logic              ex_valid_o,
    output logic              mem_valid_o,
    output logic              wb_valid_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_WAIT   = 2'd1;
    localparam logic [1:0] c_HOLD   = 2'd2;
    localparam logic [1:0] c_CANCEL = 2'd3;

    logic [1:0]       r_state;
    logic             r_id_valid;
    logic             r_ex_valid;
    logic             r_mem_valid;
    logic             r_wb_valid;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_flush;
    logic w_load_use;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_mem_allow;
    logic w_ex_allow;
    logic w_id_over;
    logic w_id_allow;
    logic w_if_over;
    logic w_req;

    assign w_flush     = r_ex_valid && jbr_taken_i;
    assign w_rs1_hit   = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    assign w_rs2_hit   = id_use_rs2_i && (id_rs2_i == ex_rd_i);
    assign w_load_use  = r_ex_valid && ex_is_load_i && (ex_rd_i != '0) && (w_rs1_hit || w_rs2_hit);

    assign w_mem_allow = !r_mem_valid || mem_over_i;
    assign w_ex_allow  = !r_ex_valid || (ex_over_i && w_mem_allow);
    assign w_id_over   = r_id_valid && !w_load_use;
    assign w_id_allow  = !r_id_valid || (w_id_over && w_ex_allow);

    assign w_req = (r_state == c_IDLE);

    always_comb begin
        w_if_over = 1'b0;
        case (r_state)
            c_WAIT:  w_if_over = inst_data_ok_i && !w_flush;
            c_HOLD:  w_if_over = !w_flush;
            default: w_if_over = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (inst_addr_ok_i) begin
                        r_state <= w_flush ? c_CANCEL : c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (inst_data_ok_i) begin
                        r_state <= (w_flush || w_id_allow) ? c_IDLE : c_HOLD;
                    end else if (w_flush) begin
                        r_state <= c_CANCEL;
                    end
                end
                c_HOLD: begin
                    if (w_id_allow || w_flush) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    // wrong-path response is swallowed here
                    if (inst_data_ok_i) begin
                        r_state <= c_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_id_valid  <= 1'b0;
            r_ex_valid  <= 1'b0;
            r_mem_valid <= 1'b0;
            r_wb_valid  <= 1'b0;
        end else begin
            if (w_flush) begin
                r_id_valid <= 1'b0;
            end else if (w_id_allow) begin
                r_id_valid <= w_if_over;
            end
            // the branch itself advances; only the instruction behind it dies
            if (w_ex_allow) begin
                r_ex_valid <= w_id_over && !w_flush;
            end
            if (w_mem_allow) begin
                r_mem_valid <= r_ex_valid && ex_over_i;
            end
            r_wb_valid <= r_mem_valid && mem_over_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
        end else if (r_id_valid && !w_id_allow && !w_flush && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign inst_req_o        = w_req;
    assign pc_en_o           = w_req && inst_addr_ok_i;
    assign ctl_if_over_o     = w_if_over;
    assign ctl_id_allow_in_o = w_id_allow;
    assign ctl_jbr_taken_o   = w_flush;
    assign id_valid_o        = r_id_valid;
    assign ex_valid_o        = r_ex_valid;
    assign mem_valid_o       = r_mem_valid;
    assign wb_valid_o        = r_wb_valid;
    assign stall_cnt_o       = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Random-stimulus bench for pipe_ctrl against a stage-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int CNT_W   = 6;
    localparam int REG_AW  = 5;
    localparam int N_CYC   = 4000;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              inst_req_o;
    logic              inst_addr_ok_i;
    logic              inst_data_ok_i;
    logic              pc_en_o;
    logic              ctl_if_over_o;
    logic              ctl_id_allow_in_o;
    logic              ctl_jbr_taken_o;
    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic              id_use_rs1_i;
    logic              id_use_rs2_i;
    logic [REG_AW-1:0] ex_rd_i;
    logic              ex_is_load_i;
    logic              ex_over_i;
    logic              mem_over_i;
    logic              jbr_taken_i;
    logic              id_valid_o;
    logic              ex_valid_o;
    logic              mem_valid_o;
    logic              wb_valid_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    always #5 clk_i = ~clk_i;

    pipe_ctrl #(.CNT_W(CNT_W), .REG_AW(REG_AW)) u_dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .inst_req_o        (inst_req_o),
        .inst_addr_ok_i    (inst_addr_ok_i),
        .inst_data_ok_i    (inst_data_ok_i),
        .pc_en_o           (pc_en_o),
        .ctl_if_over_o     (ctl_if_over_o),
        .ctl_id_allow_in_o (ctl_id_allow_in_o),
        .ctl_jbr_taken_o   (ctl_jbr_taken_o),
        .id_rs1_i          (id_rs1_i),
        .id_rs2_i          (id_rs2_i),
        .id_use_rs1_i      (id_use_rs1_i),
        .id_use_rs2_i      (id_use_rs2_i),
        .ex_rd_i           (ex_rd_i),
        .ex_is_load_i      (ex_is_load_i),
        .ex_over_i         (ex_over_i),
        .mem_over_i        (mem_over_i),
        .jbr_taken_i       (jbr_taken_i),
        .id_valid_o        (id_valid_o),
        .ex_valid_o        (ex_valid_o),
        .mem_valid_o       (mem_valid_o),
        .wb_valid_o        (wb_valid_o),
        .stall_cnt_o       (stall_cnt_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stage k: 1=ID 2=EX 3=MEM 4=WB. Fetch side tracked as
    // outstanding request / response to be discarded / instruction buffered.
    bit mv[5];
    bit md[5];
    bit ma[5];
    bit m_pending, m_discard, m_buffered;
    int m_cnt;
    bit e_flush, e_lu, e_req, e_pcen, e_ifover;

    task automatic model_reset();
        for (int s = 0; s < 5; s++) mv[s] = 1'b0;
        m_pending  = 1'b0;
        m_discard  = 1'b0;
        m_buffered = 1'b0;
        m_cnt      = 0;
    endtask

    task automatic model_comb();
        bit hit;
        hit = (id_use_rs1_i && id_rs1_i == ex_rd_i) || (id_use_rs2_i && id_rs2_i == ex_rd_i);
        e_flush = mv[2] && jbr_taken_i;
        e_lu    = mv[2] && ex_is_load_i && (ex_rd_i != 0) && hit;
        md[1] = !e_lu;
        md[2] = ex_over_i;
        md[3] = mem_over_i;
        ma[4] = 1'b1;
        for (int s = 3; s >= 1; s--) ma[s] = !mv[s] || (md[s] && ma[s+1]);
        e_req    = !m_pending && !m_buffered;
        e_pcen   = e_req && inst_addr_ok_i;
        e_ifover = !e_flush && ((m_pending && !m_discard && inst_data_ok_i) || m_buffered);
    endtask

    task automatic model_step();
        bit nv[5];
        nv[0] = 1'b0;
        nv[1] = e_flush ? 1'b0 : (ma[1] ? e_ifover : mv[1]);
        for (int s = 2; s <= 4; s++)
            nv[s] = ma[s] ? (mv[s-1] && md[s-1] && !(s == 2 && e_flush)) : mv[s];
        if (mv[1] && !ma[1] && !e_flush && m_cnt < CNT_MAX) m_cnt++;
        if (e_req && inst_addr_ok_i) begin
            m_pending = 1'b1;
            m_discard = e_flush;
        end else if (m_pending) begin
            if (inst_data_ok_i) begin
                m_pending = 1'b0;
                if (!m_discard && !e_flush && !ma[1]) m_buffered = 1'b1;
                m_discard = 1'b0;
            end else if (e_flush) begin
                m_discard = 1'b1;
            end
        end else if (m_buffered && (ma[1] || e_flush)) begin
            m_buffered = 1'b0;
        end
        for (int s = 1; s <= 4; s++) mv[s] = nv[s];
    endtask

    task automatic compare_all();
        check("inst_req",    32'(inst_req_o),        32'(e_req));
        check("pc_en",       32'(pc_en_o),           32'(e_pcen));
        check("if_over",     32'(ctl_if_over_o),     32'(e_ifover));
        check("id_allow_in", 32'(ctl_id_allow_in_o), 32'(ma[1]));
        check("jbr_taken",   32'(ctl_jbr_taken_o),   32'(e_flush));
        check("id_valid",    32'(id_valid_o),        32'(mv[1]));
        check("ex_valid",    32'(ex_valid_o),        32'(mv[2]));
        check("mem_valid",   32'(mem_valid_o),       32'(mv[3]));
        check("wb_valid",    32'(wb_valid_o),        32'(mv[4]));
        check("stall_cnt",   32'(stall_cnt_o),       32'(m_cnt));
    endtask

    initial begin
        bit in_reset;
        bit mem_stuck;
        rst_ni         = 1'b0;
        inst_addr_ok_i = 1'b0;
        inst_data_ok_i = 1'b0;
        id_rs1_i       = '0;
        id_rs2_i       = '0;
        id_use_rs1_i   = 1'b0;
        id_use_rs2_i   = 1'b0;
        ex_rd_i        = '0;
        ex_is_load_i   = 1'b0;
        ex_over_i      = 1'b0;
        mem_over_i     = 1'b0;
        jbr_taken_i    = 1'b0;
        model_reset();
        in_reset  = 1'b1;
        mem_stuck = 1'b0;

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(negedge clk_i);
            if (in_reset && cyc > 1) begin
                rst_ni   = 1'b1;
                in_reset = 1'b0;
            end else if (!in_reset && $urandom_range(0, 249) == 0) begin
                rst_ni   = 1'b0;
                in_reset = 1'b1;
                model_reset();
            end
            // occasional long memory stalls fill the pipe and saturate the counter
            if ($urandom_range(0, 39) == 0) mem_stuck = !mem_stuck;
            inst_addr_ok_i = ($urandom_range(0, 3) != 0);
            inst_data_ok_i = !in_reset && m_pending && ($urandom_range(0, 2) != 0);
            id_rs1_i       = REG_AW'($urandom_range(0, 3));
            id_rs2_i       = REG_AW'($urandom_range(0, 3));
            id_use_rs1_i   = 1'($urandom_range(0, 1));
            id_use_rs2_i   = 1'($urandom_range(0, 1));
            ex_rd_i        = REG_AW'($urandom_range(0, 3));
            ex_is_load_i   = ($urandom_range(0, 2) == 0);
            ex_over_i      = ($urandom_range(0, 3) != 0);
            mem_over_i     = !mem_stuck && ($urandom_range(0, 3) != 0);
            jbr_taken_i    = ($urandom_range(0, 6) == 0);
            #1;
            model_comb();
            compare_all();
            @(posedge clk_i);
            if (!in_reset) model_step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
